i2c_line_conditioner: RTL and testbench
=======================================

// Module: i2c_line_conditioner
// PURPOSE
//   Parametrised multi-bit successor to the single-bit D flip-flop.
//   Per channel: N-stage synchroniser, then a consecutive-sample glitch filter, then
//   registered rise/fall pulses.
//   Sits between the raw SCL/SDA pads and the I2C master/flash controller FSMs.
//   Downstream logic sees only clean, clk-domain levels and single-cycle edge strobes.
// PARAMETERS
//   WIDTH        2      number of independent channels (bit0=SCL, bit1=SDA by default)
//   SYNC_STAGES  2      synchroniser depth; legal >= 2
//   FILTER_CNT   4      consecutive differing samples required to accept a new level; legal >= 1
//   RESET_VAL    2'b11  reset/idle level of every channel (I2C bus idles high); WIDTH bits
//   GCW          8      glitch-counter width per channel (used only with LINE_GLITCH_CNT_EN)
// PORTS
//   clk         in   1           sole clock, rising edge
//   rst         in   1           synchronous, active-high reset
//   d           in   WIDTH       raw asynchronous line inputs
//   q           out  WIDTH       filtered level, registered
//   rise        out  WIDTH       1-cycle pulse, coincident with the cycle q goes 0->1
//   fall        out  WIDTH       1-cycle pulse, coincident with the cycle q goes 1->0
//   glitch_clr  in   1           (macro only) synchronous clear of all glitch counters
//   glitch_cnt  out  WIDTH*GCW   (macro only) per-channel saturating glitch counts, channel i at [i*GCW +: GCW]
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): all sync stages <= RESET_VAL, q <= RESET_VAL.
//     Filter counters <= 0; rise/fall <= 0; glitch_cnt <= 0.
//     Reset overrides all other activity, including a filter count in progress.
//     No edge pulse is generated by reset or by the first sample after it.
//   - Sync: s = last stage of a SYNC_STAGES-deep shift register; d enters stage 1 each edge.
//   - Filter (per channel i, counter cnt of width max(1,$clog2(FILTER_CNT))):
//       s==q                    : cnt<=0
//       s!=q, cnt==FILTER_CNT-1 : q<=s, cnt<=0
//       s!=q, otherwise         : cnt<=cnt+1
//     FILTER_CNT=1 -> q follows s with one cycle of delay, no filtering.
//   - Latency: a level change held on d is sampled at edge E.
//     q changes at edge E+SYNC_STAGES+FILTER_CNT-1; defaults give E+5.
//     Any d pulse shorter than FILTER_CNT cycles, as seen at s, never reaches q.
//   - Edges: rise[i] = q_next[i] & ~q[i], fall[i] = ~q_next[i] & q[i].
//     Both are registered, so the pulse is high in exactly the first cycle q holds its new value.
//     rise and fall are never both high on the same channel.
//   - Channels are fully independent; simultaneous changes on several channels update in the same cycle.
//   - s returning to q mid-count: cnt<=0, q unchanged, no pulse. This is a glitch event.
// CONFIGURATION
//   LINE_GLITCH_CNT_EN defined:
//     - Ports glitch_clr and glitch_cnt exist.
//     - glitch_cnt[i] increments by 1 on every cycle where s[i]==q[i] and cnt[i]!=0 (a rejected glitch).
//     - The count saturates at 2^GCW-1 and never wraps.
//     - glitch_clr=1 zeroes all counts next edge. glitch_clr has priority over an increment in the same cycle.
//   LINE_GLITCH_CNT_EN undefined:
//     - Ports are absent and no counter logic is generated.
//     - q, rise and fall behaviour is identical in both builds.
// TESTING (defaults unless noted)
//   1. rst=1 for 3 cycles with d=2'b00, then rst=0 and d=2'b11
//      -> q=2'b11 throughout; rise=fall=0 throughout; glitch_cnt=0.
//   2. d[0] 1->0 at edge E and held -> q[0]=0 from edge E+5.
//      fall[0]=1 for exactly that one cycle; q[1] and rise stay unchanged.
//   3. d[1]=0 for 3 cycles, then back to 1 -> q[1] stays 1 with no fall pulse.
//      glitch_cnt[1]=1 (macro build).
//   4. d[1]=0 for exactly 4 cycles -> q[1] low for exactly 4 cycles.
//      fall[1] then rise[1] pulse once each.
//   5. d[0] falls; rst=1 when cnt[0]==2 -> next edge q=2'b11, counters 0, no pulse.
//      d still 0 after rst release -> fall[0] occurs 5 cycles after the first post-reset sample.
//   6. Macro build: 300 rejected 1-cycle glitches on d[0] -> glitch_cnt[0]=255.
//      glitch_clr coinciding with a glitch -> glitch_cnt[0]=0.

Source files
------------

// File: rtl/i2c_line_conditioner.sv
// Per-channel synchroniser, consecutive-sample glitch filter and registered edge strobes for raw I2C pads.
// Optional per-channel rejected-glitch counters are built when LINE_GLITCH_CNT_EN is defined.
module i2c_line_conditioner #(
  parameter int               WIDTH       = 2,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_CNT  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b1}},
  parameter int               GCW         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall
`ifdef LINE_GLITCH_CNT_EN
  ,
  input  logic                 glitch_clr,
  output logic [WIDTH*GCW-1:0] glitch_cnt
`endif
);

  localparam int CW = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_CNT < 1) begin : g_bad_filter
    $error("FILTER_CNT must be at least 1");
  end
  if (GCW < 1) begin : g_bad_gcw
    $error("GCW must be at least 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after FILTER_CNT consecutive samples differ from q.
  always_comb begin
    q_next = q;
    reject = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s[i] != q[i]) begin
        if (cnt[i] == CW'(FILTER_CNT - 1)) q_next[i] = s[i];
        else                              cnt_next[i] = cnt[i] + CW'(1);
      end else begin
        reject[i] = (cnt[i] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      q    <= q_next;
      rise <= q_next & ~q;
      fall <= ~q_next & q;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

`ifdef LINE_GLITCH_CNT_EN
  logic [GCW-1:0] gcnt [WIDTH];

  // Counts saturate rather than wrap; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || glitch_clr) begin
      for (int i = 0; i < WIDTH; i++) gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (reject[i] && (gcnt[i] != {GCW{1'b1}})) gcnt[i] <= gcnt[i] + GCW'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pack
    assign glitch_cnt[g*GCW +: GCW] = gcnt[g];
  end
`else
  logic unused_reject;
  assign unused_reject = ^reject;
`endif

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Directed self-checking bench for i2c_line_conditioner at default parameters.
// Glitch-counter scenarios run only when LINE_GLITCH_CNT_EN is defined.
module tb_i2c_line_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] d;
  logic [1:0] q;
  logic [1:0] rise;
  logic [1:0] fall;
`ifdef LINE_GLITCH_CNT_EN
  logic        glitch_clr;
  logic [15:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  i2c_line_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .q          (q),
    .rise       (rise),
    .fall       (fall)
`ifdef LINE_GLITCH_CNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the edge they reflect.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d   = 2'b00;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (q !== 2'b11 || rise !== 2'b00 || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_hold t=%0d q=%b rise=%b fall=%b required q=11 rise=00 fall=00", t, q, rise, fall);
      end
    end
    rst = 1'b0;
    d   = 2'b11;
    for (int t = 0; t < 8; t++) begin
      tick();
      checks++;
      if (q !== 2'b11 || rise !== 2'b00 || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_release t=%0d q=%b rise=%b fall=%b required q=11 rise=00 fall=00", t, q, rise, fall);
      end
    end
`ifdef LINE_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_glitch_cnt got=%h required=0000", glitch_cnt);
    end
`endif
  endtask

  task automatic test_fall_latency();
    logic [1:0] eq, ef, er;
    d = 2'b10;
    for (int t = 1; t <= 8; t++) begin
      tick();
      eq = (t >= 6) ? 2'b10 : 2'b11;
      ef = (t == 6) ? 2'b01 : 2'b00;
      checks++;
      if (q !== eq || fall !== ef || rise !== 2'b00) begin
        errors++;
        $display("[TB] FAIL fall_latency t=%0d q=%b fall=%b rise=%b required q=%b fall=%b rise=00", t, q, fall, rise, eq, ef);
      end
    end
    d = 2'b11;
    for (int t = 1; t <= 8; t++) begin
      tick();
      eq = (t >= 6) ? 2'b11 : 2'b10;
      er = (t == 6) ? 2'b01 : 2'b00;
      checks++;
      if (q !== eq || rise !== er || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rise_latency t=%0d q=%b rise=%b fall=%b required q=%b rise=%b fall=00", t, q, rise, fall, eq, er);
      end
    end
  endtask

  task automatic test_glitch_reject();
    d = 2'b01;
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) d = 2'b11;
      tick();
      checks++;
      if (q !== 2'b11 || rise !== 2'b00 || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL glitch_reject t=%0d q=%b rise=%b fall=%b required q=11 rise=00 fall=00", t, q, rise, fall);
      end
    end
`ifdef LINE_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL glitch_count_one got=%h required=0100", glitch_cnt);
    end
`endif
  endtask

  task automatic test_min_pulse();
    logic [1:0] eq, ef, er;
    d = 2'b01;
    for (int t = 1; t <= 14; t++) begin
      if (t == 5) d = 2'b11;
      tick();
      eq = (t >= 6 && t <= 9) ? 2'b01 : 2'b11;
      ef = (t == 6)  ? 2'b10 : 2'b00;
      er = (t == 10) ? 2'b10 : 2'b00;
      checks++;
      if (q !== eq || fall !== ef || rise !== er) begin
        errors++;
        $display("[TB] FAIL min_pulse t=%0d q=%b fall=%b rise=%b required q=%b fall=%b rise=%b", t, q, fall, rise, eq, ef, er);
      end
    end
`ifdef LINE_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL min_pulse_glitch_cnt got=%h required=0100", glitch_cnt);
    end
`endif
  endtask

  task automatic test_reset_midcount();
    logic [1:0] eq, ef;
    d = 2'b10;
    for (int t = 0; t < 4; t++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (q !== 2'b11 || rise !== 2'b00 || fall !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_midcount q=%b rise=%b fall=%b required q=11 rise=00 fall=00", q, rise, fall);
    end
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      eq = (t >= 6) ? 2'b10 : 2'b11;
      ef = (t == 6) ? 2'b01 : 2'b00;
      checks++;
      if (q !== eq || fall !== ef || rise !== 2'b00) begin
        errors++;
        $display("[TB] FAIL post_reset_fall t=%0d q=%b fall=%b rise=%b required q=%b fall=%b rise=00", t, q, fall, rise, eq, ef);
      end
    end
    d = 2'b11;
    for (int t = 0; t < 8; t++) tick();
    checks++;
    if (q !== 2'b11) begin
      errors++;
      $display("[TB] FAIL post_reset_restore q=%b required=11", q);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] eq, ef, er;
    d = 2'b00;
    for (int t = 1; t <= 14; t++) begin
      if (t == 7) d = 2'b11;
      tick();
      eq = (t >= 6 && t <= 11) ? 2'b00 : 2'b11;
      ef = (t == 6)  ? 2'b11 : 2'b00;
      er = (t == 12) ? 2'b11 : 2'b00;
      checks++;
      if (q !== eq || fall !== ef || rise !== er) begin
        errors++;
        $display("[TB] FAIL simultaneous t=%0d q=%b fall=%b rise=%b required q=%b fall=%b rise=%b", t, q, fall, rise, eq, ef, er);
      end
    end
  endtask

`ifdef LINE_GLITCH_CNT_EN
  task automatic test_glitch_saturation();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    checks++;
    if (glitch_cnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL glitch_clear_idle got=%h required=0000", glitch_cnt);
    end
    for (int k = 0; k < 300; k++) begin
      d = 2'b10;
      tick();
      d = 2'b11;
      tick();
    end
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if (glitch_cnt !== 16'h00FF || q !== 2'b11) begin
      errors++;
      $display("[TB] FAIL glitch_saturate cnt=%h q=%b required cnt=00ff q=11", glitch_cnt, q);
    end
    d = 2'b10;
    tick();
    d = 2'b11;
    tick();
    tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    checks++;
    if (glitch_cnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL glitch_clr_priority got=%h required=0000", glitch_cnt);
    end
    d = 2'b10;
    tick();
    d = 2'b11;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if (glitch_cnt !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL glitch_after_clear got=%h required=0001", glitch_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    d   = 2'b11;
`ifdef LINE_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    test_reset();
    test_fall_latency();
    test_glitch_reject();
    test_min_pulse();
    test_reset_midcount();
    test_simultaneous();
`ifdef LINE_GLITCH_CNT_EN
    test_glitch_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
